vga_timing_gen: RTL

- Parametrised VGA raster timing generator. Successor to the fixed 640x480 controller.
- All porch, sync and active widths are parameters, with selectable sync polarity and a pixel clock-enable.
- Decoded outputs are registered and aligned to the pixel coordinates, so there is no decode glitch or off-by-one at the active-region edges.
- Adds line-start, frame-start and frame-count outputs. Sits between the pixel-clock domain and the game and draw logic (sprites, walls, collision).

---
 rtl/vga_timing_pkg.sv | 21 ++
 rtl/vga_timing_gen_wrap_counter.sv | 20 ++
 rtl/vga_timing_gen.sv | 105 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants, total helper and border bit indices
package vga_timing_pkg;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int TOP    = 0;
    localparam int BOTTOM = 1;
    localparam int LEFT   = 2;
    localparam int RIGHT  = 3;
    function automatic int hTotal(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction
    function automatic int vTotal(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction
endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// wrap_counter: enabled counter 0..MAX with terminal-count pulse on the wrapping cycle
module wrap_counter #(
    parameter int WIDTH = 10,
    parameter int MAX   = 799
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             tc
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX);
    assign tc = en & (q == LAST);
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (en)
            q <= (q == LAST) ? '0 : q + 1'b1;
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with registered, coordinate-aligned decodes
// Optional wall flags on border when VGA_TIMING_BORDER_EN is defined.
module vga_timing_gen import vga_timing_pkg::*; #(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int CNT_W    = 10,
    parameter int FRAME_W  = 8,
    parameter int BORDER_W = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count,
    output logic [3:0]         border
);
    localparam int H_TOTAL = hTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam bit PARAMS_OK = H_ACTIVE > 0 && H_FP > 0 && H_SYNC > 0 && H_BP > 0 &&
        V_ACTIVE > 0 && V_FP > 0 && V_SYNC > 0 && V_BP > 0 && CNT_W > 0 && FRAME_W > 0 &&
        BORDER_W > 0 && H_TOTAL <= 2 ** CNT_W && V_TOTAL <= 2 ** CNT_W;
    localparam logic [CNT_W-1:0] HA  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS0 = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS1 = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VA  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS0 = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS1 = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    logic [CNT_W-1:0] hc, vc;
    logic htc, vtc;
    logic inActive, inHsync, inVsync, atOrigin, framePending;
    wrap_counter #(.WIDTH(CNT_W), .MAX(H_TOTAL - 1)) hCounter (
        .clk(clk), .reset(reset), .en(ce), .q(hc), .tc(htc)
    );
    wrap_counter #(.WIDTH(CNT_W), .MAX(V_TOTAL - 1)) vCounter (
        .clk(clk), .reset(reset), .en(htc), .q(vc), .tc(vtc)
    );
    assign inActive = (hc < HA) && (vc < VA);
    assign inHsync  = (hc >= HS0) && (hc <= HS1);
    assign inVsync  = (vc >= VS0) && (vc <= VS1);
    assign atOrigin = (hc == '0) && (vc == '0);
    always_ff @(posedge clk) begin
        if (reset) begin
            x            <= '0;
            y            <= '0;
            active       <= 1'b0;
            hsync        <= ~SYNC_POL;
            vsync        <= ~SYNC_POL;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            frame_count  <= '0;
            framePending <= 1'b0;
        end else if (ce) begin
            x            <= hc;
            y            <= vc;
            active       <= inActive;
            hsync        <= inHsync ? SYNC_POL : ~SYNC_POL;
            vsync        <= inVsync ? SYNC_POL : ~SYNC_POL;
            line_start   <= (hc == '0);
            frame_start  <= atOrigin;
            // a frame counts as completed only once the counters have wrapped past its last pixel
            frame_count  <= (atOrigin && framePending) ? frame_count + 1'b1 : frame_count;
            framePending <= vtc ? 1'b1 : (atOrigin ? 1'b0 : framePending);
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end
`ifdef VGA_TIMING_BORDER_EN
    localparam logic [CNT_W-1:0] BW  = CNT_W'(BORDER_W);
    localparam logic [CNT_W-1:0] BR0 = CNT_W'(H_ACTIVE - BORDER_W);
    localparam logic [CNT_W-1:0] BB0 = CNT_W'(V_ACTIVE - BORDER_W);
    logic [3:0] wall;
    always_comb begin
        wall         = '0;
        wall[TOP]    = vc < BW;
        wall[BOTTOM] = vc >= BB0;
        wall[LEFT]   = hc < BW;
        wall[RIGHT]  = hc >= BR0;
    end
    always_ff @(posedge clk) begin
        if (reset)
            border <= '0;
        else if (ce)
            border <= inActive ? wall : 4'b0000;
    end
`else
    assign border = 4'b0000;
`endif
    always_ff @(posedge clk) begin
        assert (PARAMS_OK) else $error("vga_timing_gen: illegal timing parameters");
    end
endmodule
